// File: rtl/alut_pkg.sv
// Shared types and entry layout helpers for the address lookup table.
package alut_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_DST,
    CHK_DST,
    RD_SRC,
    CHK_SRC,
    WR_SRC,
    RESP
  } alut_state_e;

  localparam int ADDR_W   = 48;
  localparam int TIME_W   = 32;
  localparam int ADDR_LSB = 0;
  localparam int PORT_LSB = ADDR_W;

  // Timestamp field sits directly above the port field.
  function automatic int time_lsb(input int port_w);
    return PORT_LSB + port_w;
  endfunction

  // Total entry width: {valid, time, port, addr}.
  function automatic int entry_w(input int port_w);
    return 1 + TIME_W + port_w + ADDR_W;
  endfunction

endpackage

// File: rtl/alut_hash.sv
// Folds a 48-bit MAC address into a table index by XORing HASH_W-bit chunks.
module alut_hash #(
  parameter int HASH_W = 8
) (
  input  logic [47:0]       i_addr,
  output logic [HASH_W-1:0] o_hash
);

  localparam int NCH = (48 + HASH_W - 1) / HASH_W;

  logic [NCH*HASH_W-1:0] w_padded;

  // Zero-extend so the top chunk is padded when 48 is not a multiple of HASH_W.
  assign w_padded = (NCH*HASH_W)'(i_addr);

  // XOR every chunk together.
  always_comb begin
    o_hash = '0;
    for (int i = 0; i < NCH; i++) begin
      o_hash = o_hash ^ w_padded[i*HASH_W +: HASH_W];
    end
  end

endmodule

// File: rtl/alut_addr_lookup.sv
// Ethernet address lookup: destination port resolution with ageing, plus
// optional source learning into an external single-port table.
//
// state   | meaning
// IDLE    | waiting for a request; switch-address match resolves here
// RD_DST  | table read issued at hash(d_addr)
// CHK_DST | read data checked for a fresh matching entry
// RD_SRC  | table read issued at hash(s_addr)
// CHK_SRC | slot checked for eviction of a different address
// WR_SRC  | source entry written back
// RESP    | result held until consumed
module alut_addr_lookup
  import alut_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int HASH_W    = 8,
  localparam int PORT_W    = $clog2(NUM_PORTS),
  localparam int ENTRY_W   = entry_w(PORT_W)
) (
  input  logic               pclk,
  input  logic               p_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [47:0]        d_addr,
  input  logic [47:0]        s_addr,
  input  logic [PORT_W-1:0]  s_port,
  input  logic [47:0]        mac_addr,
  input  logic [31:0]        curr_time,
  input  logic [31:0]        age_limit,
  input  logic               learn_en,
  output logic [HASH_W-1:0]  mem_addr,
  output logic               mem_wr,
  output logic [ENTRY_W-1:0] mem_wdata,
  input  logic [ENTRY_W-1:0] mem_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [NUM_PORTS:0] d_port,
  output logic               reused,
  input  logic               clear_reused,
  output logic [47:0]        lst_inv_addr,
  output logic [PORT_W-1:0]  lst_inv_port,
  output logic               busy
);

  localparam int TIME_LSB  = time_lsb(PORT_W);
  localparam int VALID_BIT = ENTRY_W - 1;

  alut_state_e r_state;
  alut_state_e w_nxt_state;

  // mac_addr is only consulted at accept time, so it is not held afterwards.
  logic [47:0]          r_d_addr;
  logic [47:0]          r_s_addr;
  logic [PORT_W-1:0]    r_s_port;
  logic [31:0]          r_age_limit;
  logic                 r_learn_en;
  logic [NUM_PORTS:0]   r_d_port;
  logic                 r_reused;
  logic [47:0]          r_lst_inv_addr;
  logic [PORT_W-1:0]    r_lst_inv_port;

  logic [HASH_W-1:0]    w_dst_hash;
  logic [HASH_W-1:0]    w_src_hash;
  logic                 w_accept;
  logic                 w_mac_hit;
  logic                 w_rd_valid;
  logic [31:0]          w_rd_time;
  logic [PORT_W-1:0]    w_rd_port;
  logic [47:0]          w_rd_addr;
  logic [31:0]          w_age;
  logic                 w_hit;
  logic [NUM_PORTS-1:0] w_src_onehot;
  logic [NUM_PORTS:0]   w_flood;
  logic [NUM_PORTS:0]   w_hit_mask;
  logic                 w_reuse;

  alut_hash #(.HASH_W(HASH_W)) u_hash_dst (
    .i_addr (r_d_addr),
    .o_hash (w_dst_hash)
  );

  alut_hash #(.HASH_W(HASH_W)) u_hash_src (
    .i_addr (r_s_addr),
    .o_hash (w_src_hash)
  );

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_mac_hit  = (d_addr == mac_addr);

  assign w_rd_valid = mem_rdata[VALID_BIT];
  assign w_rd_time  = mem_rdata[TIME_LSB +: 32];
  assign w_rd_port  = mem_rdata[PORT_LSB +: PORT_W];
  assign w_rd_addr  = mem_rdata[ADDR_LSB +: 48];

  // Age is modular so a timestamp from before the counter wrapped still ages correctly.
  assign w_age      = curr_time - w_rd_time;
  assign w_hit      = w_rd_valid && (w_rd_addr == r_d_addr) && (w_age <= r_age_limit);

  assign w_src_onehot = NUM_PORTS'(1) << r_s_port;
  assign w_flood      = {1'b0, ~w_src_onehot};
  assign w_hit_mask   = {1'b0, (NUM_PORTS'(1) << w_rd_port) & ~w_src_onehot};

  assign w_reuse = (r_state == CHK_SRC) && w_rd_valid && (w_rd_addr != r_s_addr);

  // State register.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) r_state <= IDLE;
    else         r_state <= w_nxt_state;
  end

  // Next-state selection.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nxt_state = w_mac_hit ? RESP : RD_DST;
      RD_DST:  w_nxt_state = CHK_DST;
      CHK_DST: w_nxt_state = r_learn_en ? RD_SRC : RESP;
      RD_SRC:  w_nxt_state = CHK_SRC;
      CHK_SRC: w_nxt_state = WR_SRC;
      WR_SRC:  w_nxt_state = RESP;
      RESP:    if (resp_ready) w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // Table address and write strobe per state; the write reuses the source slot.
  always_comb begin
    mem_addr = '0;
    mem_wr   = 1'b0;
    case (r_state)
      RD_DST:                   mem_addr = w_dst_hash;
      RD_SRC, CHK_SRC:          mem_addr = w_src_hash;
      WR_SRC: begin
        mem_addr = w_src_hash;
        mem_wr   = 1'b1;
      end
      default: mem_addr = '0;
    endcase
  end

  assign mem_wdata  = {1'b1, curr_time, r_s_port, r_s_addr};
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign busy       = (r_state != IDLE);

  // Capture the request on accept.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      r_d_addr    <= '0;
      r_s_addr    <= '0;
      r_s_port    <= '0;
      r_age_limit <= '0;
      r_learn_en  <= 1'b0;
    end else if (w_accept) begin
      r_d_addr    <= d_addr;
      r_s_addr    <= s_addr;
      r_s_port    <= s_port;
      r_age_limit <= age_limit;
      r_learn_en  <= learn_en;
    end
  end

  // Egress mask: switch-only on own address, otherwise resolved from the table.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      r_d_port <= '1;
    end else if (w_accept && w_mac_hit) begin
      r_d_port <= {1'b1, {NUM_PORTS{1'b0}}};
    end else if (r_state == CHK_DST) begin
      r_d_port <= (r_d_addr[40] || !w_hit) ? w_flood : w_hit_mask;
    end
  end

  // Sticky eviction flag and record of the evicted entry; a new eviction beats a clear.
  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      r_reused       <= 1'b0;
      r_lst_inv_addr <= '0;
      r_lst_inv_port <= '0;
    end else if (w_reuse) begin
      r_reused       <= 1'b1;
      r_lst_inv_addr <= w_rd_addr;
      r_lst_inv_port <= w_rd_port;
    end else if (clear_reused) begin
      r_reused       <= 1'b0;
    end
  end

  assign d_port       = r_d_port;
  assign reused       = r_reused;
  assign lst_inv_addr = r_lst_inv_addr;
  assign lst_inv_port = r_lst_inv_port;

endmodule

// File: tb/tb_alut_addr_lookup.sv
// Directed bench for alut_addr_lookup with behavioural table memories.
module tb_alut_addr_lookup;

  localparam int EW  = 83;
  localparam int EW8 = 84;

  localparam logic [47:0] MAC = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] A   = 48'h0000_0000_0012;
  localparam logic [47:0] M   = 48'h0100_0000_0012;
  localparam logic [47:0] S   = 48'h0000_0000_3400;
  localparam logic [47:0] B   = 48'h0000_0000_0034;

  logic pclk = 1'b0;
  logic p_reset = 1'b1;
  always #5 pclk = ~pclk;

  logic [47:0] d_addr = '0, s_addr = '0, mac_addr = MAC;
  logic [31:0] curr_time = '0, age_limit = '0;
  logic        learn_en = 1'b0, resp_ready = 1'b0, clear_reused = 1'b0;

  logic          req_valid = 1'b0, req_ready, mem_wr, resp_valid, reused, busy;
  logic [1:0]    s_port = '0, lst_inv_port;
  logic [7:0]    mem_addr;
  logic [EW-1:0] mem_wdata, mem_rdata;
  logic [4:0]    d_port;
  logic [47:0]   lst_inv_addr;

  logic           req_valid8 = 1'b0, req_ready8, mem_wr8, resp_valid8, reused8, busy8;
  logic [2:0]     s_port8 = '0, lst_inv_port8;
  logic [9:0]     mem_addr8;
  logic [EW8-1:0] mem_wdata8, mem_rdata8;
  logic [8:0]     d_port8;
  logic [47:0]    lst_inv_addr8;

  alut_addr_lookup dut (
    .pclk(pclk), .p_reset(p_reset), .req_valid(req_valid), .req_ready(req_ready),
    .d_addr(d_addr), .s_addr(s_addr), .s_port(s_port), .mac_addr(mac_addr),
    .curr_time(curr_time), .age_limit(age_limit), .learn_en(learn_en),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .d_port(d_port), .reused(reused),
    .clear_reused(clear_reused), .lst_inv_addr(lst_inv_addr), .lst_inv_port(lst_inv_port),
    .busy(busy)
  );

  alut_addr_lookup #(.NUM_PORTS(8), .HASH_W(10)) dut8 (
    .pclk(pclk), .p_reset(p_reset), .req_valid(req_valid8), .req_ready(req_ready8),
    .d_addr(d_addr), .s_addr(s_addr), .s_port(s_port8), .mac_addr(mac_addr),
    .curr_time(curr_time), .age_limit(age_limit), .learn_en(learn_en),
    .mem_addr(mem_addr8), .mem_wr(mem_wr8), .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8),
    .resp_valid(resp_valid8), .resp_ready(resp_ready), .d_port(d_port8), .reused(reused8),
    .clear_reused(clear_reused), .lst_inv_addr(lst_inv_addr8), .lst_inv_port(lst_inv_port8),
    .busy(busy8)
  );

  // Table models: one-cycle read latency, cleared while reset is held.
  logic [EW-1:0]  mem  [0:255];
  logic [EW8-1:0] mem8 [0:1023];
  logic           pl_en = 1'b0, pl_en8 = 1'b0;
  logic [7:0]     pl_addr = '0;
  logic [9:0]     pl_addr8 = '0;
  logic [EW-1:0]  pl_data = '0;
  logic [EW8-1:0] pl_data8 = '0;

  always @(posedge pclk) begin
    if (p_reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge pclk) begin
    if (p_reset) begin
      for (int i = 0; i < 1024; i++) mem8[i] <= '0;
    end else if (pl_en8) mem8[pl_addr8] <= pl_data8;
    mem_rdata8 <= mem8[mem_addr8];
  end

  int            wr_total = 0, acc_total = 0;
  logic [7:0]    last_waddr = '0;
  logic [EW-1:0] last_wdata = '0;

  always @(posedge pclk) begin
    if (mem_wr) begin
      wr_total   <= wr_total + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_wr || mem_addr != 8'h00) acc_total <= acc_total + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic preload(input logic [7:0] a, input logic [EW-1:0] d);
    @(negedge pclk); pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge pclk); pl_en = 1'b0;
  endtask

  task automatic preload8(input logic [9:0] a, input logic [EW8-1:0] d);
    @(negedge pclk); pl_en8 = 1'b1; pl_addr8 = a; pl_data8 = d;
    @(negedge pclk); pl_en8 = 1'b0;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_req(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] sp,
                          input logic [31:0] ct, input logic [31:0] al, input logic le);
    @(negedge pclk);
    d_addr = da; s_addr = sa; s_port = sp; curr_time = ct; age_limit = al; learn_en = le;
    req_valid = 1'b1;
    @(posedge pclk); #1;
    req_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; -1 means the response never came.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge pclk); #1; lat++;
    end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  task automatic finish_resp;
    resp_ready = 1'b1;
    @(posedge pclk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    p_reset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (d_port !== 5'b11111) begin n_err++; $display("FAIL rst_d_port got %b want 11111", d_port); end
    n_cmp++; if (reused !== 1'b0) begin n_err++; $display("FAIL rst_reused got %b want 0", reused); end
    n_cmp++; if (lst_inv_addr !== 48'h0 || lst_inv_port !== 2'd0) begin n_err++; $display("FAIL rst_lst_inv got %h/%0d want 0/0", lst_inv_addr, lst_inv_port); end
    n_cmp++; if (mem_wr !== 1'b0 || mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_mem got wr=%b addr=%h want 0/00", mem_wr, mem_addr); end
    n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_resp_busy got %b/%b want 0/0", resp_valid, busy); end
    @(negedge pclk); p_reset = 1'b0;
    @(posedge pclk); #1;
    n_cmp++; if (d_port !== 5'b11111 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_after_release got %b/%b want 11111/1", d_port, req_ready); end
  endtask

  task automatic test_mac_match;
    int a0, w0;
    a0 = acc_total; w0 = wr_total;
    send_req(MAC, S, 2'd0, 32'd10, 32'd100, 1'b1);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL mac_latency resp_valid got %b want 1 after one cycle", resp_valid); end
    n_cmp++; if (d_port !== 5'b10000) begin n_err++; $display("FAIL mac_d_port got %b want 10000", d_port); end
    finish_resp;
    n_cmp++; if (acc_total !== a0 || wr_total !== w0) begin n_err++; $display("FAIL mac_no_mem got acc=%0d wr=%0d want %0d/%0d", acc_total, wr_total, a0, w0); end
  endtask

  task automatic test_dst_lookup;
    int lat, w0;
    preload(8'h12, {1'b1, 32'd100, 2'd2, A});
    preload(8'h13, {1'b1, 32'd100, 2'd2, M});
    w0 = wr_total;
    send_req(A, S, 2'd0, 32'd150, 32'd100, 1'b0);
    n_cmp++; if (mem_addr !== 8'h12) begin n_err++; $display("FAIL dst_hash got %h want 12", mem_addr); end
    wait_resp(lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL dst_latency got %0d want 3", lat); end
    n_cmp++; if (d_port !== 5'b00100) begin n_err++; $display("FAIL dst_hit got %b want 00100", d_port); end
    finish_resp;
    send_req(A, S, 2'd0, 32'd300, 32'd100, 1'b0); wait_resp(lat);
    n_cmp++; if (d_port !== 5'b01110) begin n_err++; $display("FAIL dst_stale got %b want 01110", d_port); end
    finish_resp;
    send_req(A, S, 2'd0, 32'd200, 32'd100, 1'b0); wait_resp(lat);
    n_cmp++; if (d_port !== 5'b00100) begin n_err++; $display("FAIL dst_age_edge got %b want 00100", d_port); end
    finish_resp;
    send_req(A, S, 2'd0, 32'd201, 32'd100, 1'b0); wait_resp(lat);
    n_cmp++; if (d_port !== 5'b01110) begin n_err++; $display("FAIL dst_age_over got %b want 01110", d_port); end
    finish_resp;
    send_req(A, S, 2'd2, 32'd150, 32'd100, 1'b0); wait_resp(lat);
    n_cmp++; if (d_port !== 5'b00000) begin n_err++; $display("FAIL dst_same_port got %b want 00000", d_port); end
    finish_resp;
    send_req(M, S, 2'd1, 32'd150, 32'd100, 1'b0); wait_resp(lat);
    n_cmp++; if (d_port !== 5'b01101) begin n_err++; $display("FAIL dst_multicast got %b want 01101", d_port); end
    finish_resp;
    n_cmp++; if (wr_total !== w0) begin n_err++; $display("FAIL dst_no_write got %0d want %0d", wr_total, w0); end
  endtask

  task automatic test_learn;
    int lat, w0;
    preload(8'h34, {1'b1, 32'd50, 2'd3, B});
    w0 = wr_total;
    send_req(A, S, 2'd1, 32'd150, 32'd100, 1'b1);
    wait_resp(lat);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL learn_latency got %0d want 6", lat); end
    n_cmp++; if (d_port !== 5'b00100) begin n_err++; $display("FAIL learn_d_port got %b want 00100", d_port); end
    n_cmp++; if (reused !== 1'b1) begin n_err++; $display("FAIL learn_reused got %b want 1", reused); end
    n_cmp++; if (lst_inv_addr !== B || lst_inv_port !== 2'd3) begin n_err++; $display("FAIL learn_lst_inv got %h/%0d want %h/3", lst_inv_addr, lst_inv_port, B); end
    n_cmp++; if (wr_total !== w0 + 1 || last_waddr !== 8'h34) begin n_err++; $display("FAIL learn_write got n=%0d addr=%h want %0d/34", wr_total, last_waddr, w0 + 1); end
    n_cmp++; if (last_wdata !== {1'b1, 32'd150, 2'd1, S}) begin n_err++; $display("FAIL learn_wdata got %h want %h", last_wdata, {1'b1, 32'd150, 2'd1, S}); end
    finish_resp;
    @(negedge pclk); clear_reused = 1'b1;
    @(negedge pclk); clear_reused = 1'b0;
    n_cmp++; if (reused !== 1'b0) begin n_err++; $display("FAIL clear_reused got %b want 0", reused); end
    send_req(A, S, 2'd1, 32'd160, 32'd100, 1'b1);
    wait_resp(lat);
    n_cmp++; if (reused !== 1'b0 || lst_inv_addr !== B) begin n_err++; $display("FAIL relearn_no_reuse got %b/%h want 0/%h", reused, lst_inv_addr, B); end
    n_cmp++; if (wr_total !== w0 + 2 || last_wdata !== {1'b1, 32'd160, 2'd1, S}) begin n_err++; $display("FAIL relearn_write got n=%0d d=%h", wr_total, last_wdata); end
    finish_resp;
  endtask

  task automatic test_back_to_back;
    int lat;
    preload(8'h34, {1'b1, 32'd50, 2'd3, B});
    send_req(A, S, 2'd3, 32'd150, 32'd100, 1'b1);
    repeat (3) @(posedge pclk);
    #1; clear_reused = 1'b1;
    @(posedge pclk); #1;
    n_cmp++; if (reused !== 1'b1) begin n_err++; $display("FAIL set_beats_clear got %b want 1", reused); end
    clear_reused = 1'b0;
    wait_resp(lat);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_resp got %b want 1", resp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      n_cmp++;
      if (d_port !== 5'b00100 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cycle %0d got d=%b v=%b rdy=%b want 00100/1/0", i, d_port, resp_valid, req_ready);
      end
    end
    finish_resp;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_midop;
    int w0;
    preload(8'h34, {1'b1, 32'd50, 2'd3, B});
    w0 = wr_total;
    send_req(A, S, 2'd1, 32'd150, 32'd100, 1'b1);
    repeat (2) @(posedge pclk);
    #2; p_reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL midrst_state got busy=%b v=%b wr=%b want 0/0/0", busy, resp_valid, mem_wr); end
    n_cmp++; if (d_port !== 5'b11111 || reused !== 1'b0 || lst_inv_addr !== 48'h0) begin n_err++; $display("FAIL midrst_regs got %b/%b/%h", d_port, reused, lst_inv_addr); end
    repeat (2) @(posedge pclk);
    @(negedge pclk); p_reset = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
    n_cmp++; if (wr_total !== w0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_abort got wr=%0d v=%b want %0d/0", wr_total, resp_valid, w0); end
  endtask

  task automatic test_wrap_wide;
    int lat;
    preload8(10'h012, {1'b1, 32'hFFFF_FFF0, 3'd5, A});
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      d_addr = A; s_addr = S; s_port8 = 3'd0; learn_en = 1'b0; age_limit = 32'h40;
      curr_time = (k == 0) ? 32'h10 : 32'h31;
      req_valid8 = 1'b1;
      @(posedge pclk); #1;
      req_valid8 = 1'b0;
      lat = 1;
      while (resp_valid8 !== 1'b1 && lat < 20) begin @(posedge pclk); #1; lat++; end
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wide_latency k=%0d got %0d want 3", k, lat); end
      if (k == 0) begin
        n_cmp++; if (d_port8 !== 9'b0_0010_0000) begin n_err++; $display("FAIL wide_wrap_hit got %b want 000100000", d_port8); end
      end else begin
        n_cmp++; if (d_port8 !== 9'b0_1111_1110) begin n_err++; $display("FAIL wide_wrap_stale got %b want 011111110", d_port8); end
      end
      finish_resp;
    end
  endtask

  initial begin
    test_reset;
    test_mac_match;
    test_dst_lookup;
    test_learn;
    test_back_to_back;
    test_reset_midop;
    test_wrap_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
